phv_stage_fifo: RTL and testbench
=================================

Name: phv_stage_fifo

Overview:
- Elastic PHV buffer placed directly downstream of a match-action stage output (phv_out/phv_out_valid).
- The stage has no backpressure, so this block absorbs its PHV stream and presents it to the next consumer (the next stage or the deparser) over a valid/ready handshake.
- Full-condition losses are counted and flagged, never silently stalled.

Parameters:
- PHV_LEN, 1579, PHV width in bits (1024+7+24*8+5*20+256).
- DEPTH, 8, total PHV capacity including the output head register; power of two, minimum 4.
- ADDR_W, 3, log2(DEPTH).
- AF_MARGIN, 2, almost_full asserts when fifo_count >= DEPTH-AF_MARGIN.

Ports:
- axis_clk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous reset, active-high (asserted = 1). The port name keeps the codebase's existing reset port name despite the "n" suffix; polarity is high.
- phv_in  in  PHV_LEN  PHV from upstream stage.
- phv_in_valid  in  1  single-cycle qualifier; no ready returned upstream.
- phv_out  out  PHV_LEN  head PHV, registered.
- phv_out_valid  out  1  head valid, registered.
- phv_out_ready  in  1  downstream accepts head when high together with phv_out_valid.
- fifo_count  out  ADDR_W+1  entries held, 0..DEPTH, including the head register.
- almost_full  out  1  registered, fifo_count >= DEPTH-AF_MARGIN.
- drop_pulse  out  1  registered one-cycle pulse per dropped PHV.
- drop_cnt  out  32  saturating count of dropped PHVs.

Behaviour:
- Reset (async assert, sync deassert in use): all pointers 0, fifo_count 0, phv_out 0, phv_out_valid 0, almost_full 0, drop_pulse 0, drop_cnt 0. Buffered contents are discarded on reset mid-operation; no partial PHV survives.
- Definitions: push = phv_in_valid; pop = phv_out_valid & phv_out_ready.
- Accept rule:
  - Push is accepted if fifo_count < DEPTH, or if pop occurs in the same cycle (full with simultaneous pop: accept, no drop).
  - Otherwise the PHV is dropped: drop_pulse = 1 next cycle, and drop_cnt increments, saturating at 32'hFFFF_FFFF.
- Storage:
  - Head register (phv_out) plus DEPTH-1 entry memory, circular with wrap-around pointers of ADDR_W bits.
  - Order is strict FIFO.
- Head refill:
  - If head is empty or popped this cycle, the next head comes from memory if memory is non-empty; otherwise it comes directly from an accepted phv_in (bypass).
  - Otherwise an accepted phv_in is written to memory.
- Latency: PHV accepted at edge k into an empty block produces phv_out_valid = 1 and phv_out = that PHV after edge k. One cycle, no bubble.
- Throughput: one PHV per cycle sustained when phv_out_ready = 1.
- Stability: while phv_out_valid = 1 and phv_out_ready = 0, phv_out and phv_out_valid hold unchanged. When empty, phv_out holds its last value and phv_out_valid = 0.
- fifo_count: next = count + accepted_push − pop. Range 0..DEPTH and never exceeds DEPTH. almost_full and fifo_count update on the same edge.
- phv_out_ready with phv_out_valid = 0 has no effect.
- No combinational path from phv_out_ready to any output.

Test Plan:
- Reset, then single push of PHV 0xA5-pattern with ready = 1 → phv_out_valid high one cycle after acceptance edge, phv_out = pattern, fifo_count 1→0 next cycle, drop_cnt 0.
- Ready = 0, push 8 PHVs tagged 1..8 on consecutive cycles → fifo_count = 8, almost_full high once count reaches 6. Then ready = 1 → outputs 1..8 in order, one per cycle, count back to 0.
- Full with ready = 0, push 3 more → drop_pulse high 3 cycles, drop_cnt = 3, contents still 1..8.
- Full, ready = 1 and push same cycle, continuous for 20 cycles → no drops, count stays 8, output order exact. Covers pointer wrap-around at least twice.
- Random ready (50%) with back-to-back pushes, 1000 PHVs against a scoreboard → every accepted PHV delivered once in order. drop_cnt equals the scoreboard drop count; phv_out stable while stalled.
- Assert aresetn mid-burst with count = 5 → all outputs 0 immediately. After release, the first new PHV appears with no stale data; preload drop_cnt near saturation → holds at FFFF_FFFF.

Source files
------------

// File: rtl/phv_stage_fifo_if.sv
// PHV stream bundle around the stage FIFO: the unqualified push side from the
// match-action stage and the valid/ready head side toward the next consumer.
interface phv_stage_fifo_if #(
    parameter int PHV_LEN = 1579
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;

    // FIFO side: takes the stage output, presents the head
    modport slave (
        input  phv_in,
        input  phv_in_valid,
        output phv_out,
        output phv_out_valid,
        input  phv_out_ready
    );

    // Environment side: the upstream stage plus the downstream consumer
    modport master (
        output phv_in,
        output phv_in_valid,
        input  phv_out,
        input  phv_out_valid,
        output phv_out_ready
    );
endinterface

// File: rtl/phv_stage_fifo.sv
// Elastic PHV buffer behind a match-action stage. The stage cannot be stalled,
// so a PHV arriving when the block is full (and nothing leaves that cycle) is
// dropped, flagged with drop_pulse and counted in a saturating drop_cnt.
// Storage is a registered head (phv_out) plus a circular memory; an empty
// block bypasses the memory so an accepted PHV is visible one edge later.
module phv_stage_fifo #(
    parameter int PHV_LEN   = 1579,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic                axis_clk,
    input  logic                aresetn,     // active-high despite the name
    phv_stage_fifo_if.slave     bus,
    output logic [ADDR_W:0]     fifo_count,
    output logic                almost_full,
    output logic                drop_pulse,
    output logic [31:0]         drop_cnt
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(DEPTH - AF_MARGIN);

    // The memory only ever holds DEPTH-1 entries (the head holds the rest);
    // it is sized DEPTH so the ADDR_W-bit pointers wrap without compare logic.
    logic [PHV_LEN-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  rd_ptr_reg;
    logic [ADDR_W:0]    count_reg;
    logic [ADDR_W:0]    count_next;
    logic [ADDR_W:0]    mem_count;
    logic [PHV_LEN-1:0] head_reg;
    logic               head_valid_reg;
    logic               almost_full_reg;
    logic               drop_pulse_reg;
    logic [31:0]        drop_cnt_reg;

    logic push;
    logic pop;
    logic accept;
    logic head_free;
    logic mem_empty;
    logic mem_rd;
    logic mem_wr;
    logic bypass;

    // Handshake decode: who moves where this cycle
    always_comb begin
        push       = bus.phv_in_valid;
        pop        = head_valid_reg & bus.phv_out_ready;
        // A full block still accepts when the head leaves in the same cycle
        accept     = push & ((count_reg < FULL_LVL) | pop);
        head_free  = ~head_valid_reg | pop;
        mem_count  = count_reg - {{ADDR_W{1'b0}}, head_valid_reg};
        mem_empty  = (mem_count == '0);
        // Older entries in memory always refill the head before new input
        mem_rd     = head_free & ~mem_empty;
        bypass     = head_free & mem_empty & accept;
        mem_wr     = accept & ~bypass;
        count_next = count_reg + {{ADDR_W{1'b0}}, accept}
                               - {{ADDR_W{1'b0}}, pop};
    end

    // Entry memory write; contents need no reset since pointers and count do
    always_ff @(posedge axis_clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= bus.phv_in;
        end
    end

    // Head register refill from memory or bypass; holds while stalled or empty
    always_ff @(posedge axis_clk or posedge aresetn) begin
        if (aresetn) begin
            head_reg       <= '0;
            head_valid_reg <= 1'b0;
        end else if (mem_rd) begin
            head_reg       <= mem[rd_ptr_reg];
            head_valid_reg <= 1'b1;
        end else if (bypass) begin
            head_reg       <= bus.phv_in;
            head_valid_reg <= 1'b1;
        end else if (pop) begin
            head_valid_reg <= 1'b0;
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge axis_clk or posedge aresetn) begin
        if (aresetn) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            almost_full_reg <= 1'b0;
            drop_pulse_reg  <= 1'b0;
            drop_cnt_reg    <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg       <= count_next;
            almost_full_reg <= (count_next >= AF_LVL);
            drop_pulse_reg  <= push & ~accept;
            if (push && !accept && drop_cnt_reg != 32'hFFFF_FFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.phv_out       = head_reg;
    assign bus.phv_out_valid = head_valid_reg;
    assign fifo_count        = count_reg;
    assign almost_full       = almost_full_reg;
    assign drop_pulse        = drop_pulse_reg;
    assign drop_cnt          = drop_cnt_reg;

endmodule

// File: tb/tb_phv_stage_fifo.sv
// Bench for phv_stage_fifo: directed sequences plus a long random-ready run,
// all compared cycle by cycle against a queue-based model of the buffer.
module tb_phv_stage_fifo;

    localparam int PHV_LEN   = 1579;
    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int AF_MARGIN = 2;

    logic              axis_clk = 1'b0;
    logic              aresetn  = 1'b1;
    logic [ADDR_W:0]   fifo_count;
    logic              almost_full;
    logic              drop_pulse;
    logic [31:0]       drop_cnt;

    phv_stage_fifo_if #(.PHV_LEN(PHV_LEN)) bus ();

    phv_stage_fifo #(
        .PHV_LEN  (PHV_LEN),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .AF_MARGIN(AF_MARGIN)
    ) dut (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .bus        (bus),
        .fifo_count (fifo_count),
        .almost_full(almost_full),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    // Reference model: contents in arrival order, last value shown on phv_out
    logic [PHV_LEN-1:0] model_q[$];
    logic [PHV_LEN-1:0] model_last;
    logic [31:0]        model_drops;
    logic               model_drop_pulse;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 n_xfer   = 0;

    task automatic check_val(input string tag, input logic [PHV_LEN-1:0] obs,
                             input logic [PHV_LEN-1:0] exp);
        int diff_bit;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            diff_bit = -1;
            for (int i = 0; i < PHV_LEN; i++) begin
                if (diff_bit < 0 && obs[i] !== exp[i]) diff_bit = i;
            end
            $display("FAIL %s: got %h required %h (low 64 bits, first differing bit %0d)",
                     tag, obs[63:0], exp[63:0], diff_bit);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] rand_phv(input int tag);
        logic [PHV_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < (PHV_LEN + 31) / 32; i++) begin
            r = {r[PHV_LEN-33:0], $urandom()};
        end
        r[15:0] = tag[15:0];
        return r;
    endfunction

    function automatic logic [PHV_LEN-1:0] tag_phv(input int tag);
        logic [PHV_LEN-1:0] r;
        r = '0;
        r[31:0] = tag;
        return r;
    endfunction

    task automatic model_reset();
        model_q.delete();
        model_last       = '0;
        model_drops      = '0;
        model_drop_pulse = 1'b0;
    endtask

    // Compare every output against the model (called #1 after an edge)
    task automatic check_outputs(input string ctx);
        logic [PHV_LEN-1:0] exp_out;
        exp_out = (model_q.size() != 0) ? model_q[0] : model_last;
        check_val({ctx, ".valid"}, PHV_LEN'(bus.phv_out_valid), PHV_LEN'(model_q.size() != 0));
        check_val({ctx, ".phv_out"}, bus.phv_out, exp_out);
        check_val({ctx, ".count"}, PHV_LEN'(fifo_count), PHV_LEN'(model_q.size()));
        check_val({ctx, ".almost_full"}, PHV_LEN'(almost_full),
                  PHV_LEN'(model_q.size() >= DEPTH - AF_MARGIN));
        check_val({ctx, ".drop_pulse"}, PHV_LEN'(drop_pulse), PHV_LEN'(model_drop_pulse));
        check_val({ctx, ".drop_cnt"}, PHV_LEN'(drop_cnt), PHV_LEN'(model_drops));
    endtask

    // One clock of stimulus; entered and left #1 after a rising edge
    task automatic cyc(input string ctx, input logic v, input logic [PHV_LEN-1:0] d,
                       input logic r);
        bit pop;
        bit acc;
        bus.phv_in_valid  = v;
        bus.phv_in        = d;
        bus.phv_out_ready = r;
        pop = (model_q.size() != 0) && r;
        acc = v && ((model_q.size() < DEPTH) || pop);
        if (pop) begin
            model_last = model_q.pop_front();
            n_xfer++;
            $display("xfer %0d phv[31:0]=%h", n_xfer, model_last[31:0]);
        end
        if (acc) model_q.push_back(d);
        model_drop_pulse = v && !acc;
        if (model_drop_pulse && model_drops != 32'hFFFF_FFFF) model_drops++;
        @(posedge axis_clk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic drain(input string ctx);
        for (int i = 0; i < DEPTH + 2; i++) cyc(ctx, 1'b0, '0, 1'b1);
    endtask

    logic [PHV_LEN-1:0] pat_a5;

    initial begin
        bus.phv_in        = '0;
        bus.phv_in_valid  = 1'b0;
        bus.phv_out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge axis_clk);
        #1;
        aresetn = 1'b0;
        check_outputs("reset");

        // Single A5-pattern PHV, one-cycle latency then empty again
        pat_a5 = '0;
        for (int i = 0; i < (PHV_LEN + 7) / 8; i++) pat_a5 = {pat_a5[PHV_LEN-9:0], 8'hA5};
        cyc("single_push", 1'b1, pat_a5, 1'b1);
        cyc("single_pop", 1'b0, '0, 1'b1);

        // Fill with tags 1..8 under stall, then drain in order
        for (int t = 1; t <= 8; t++) cyc("fill", 1'b1, tag_phv(t), 1'b0);
        check_val("full_count", PHV_LEN'(fifo_count), PHV_LEN'(8));
        drain("drain");
        check_val("empty_count", PHV_LEN'(fifo_count), PHV_LEN'(0));

        // Full, stalled: three pushes are dropped, contents untouched
        for (int t = 1; t <= 8; t++) cyc("fill2", 1'b1, tag_phv(t), 1'b0);
        for (int t = 9; t <= 11; t++) cyc("overflow", 1'b1, tag_phv(t), 1'b0);
        check_val("drop_cnt_3", PHV_LEN'(drop_cnt), PHV_LEN'(3));

        // Full with simultaneous push and pop: no drops, pointers wrap
        for (int t = 100; t < 120; t++) cyc("full_stream", 1'b1, tag_phv(t), 1'b1);
        check_val("stream_count", PHV_LEN'(fifo_count), PHV_LEN'(8));
        check_val("stream_drops", PHV_LEN'(drop_cnt), PHV_LEN'(3));
        drain("drain2");

        // Back-to-back random PHVs against 50% random ready
        for (int t = 0; t < 1000; t++) begin
            cyc("random", 1'b1, rand_phv(t), 1'($urandom_range(0, 1)));
        end
        drain("drain3");

        // Reset in the middle of a burst with five entries held
        for (int t = 1; t <= 5; t++) cyc("pre_reset", 1'b1, rand_phv(t), 1'b0);
        check_val("pre_reset_count", PHV_LEN'(fifo_count), PHV_LEN'(5));
        bus.phv_in_valid = 1'b0;
        #3;
        aresetn = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge axis_clk);
        #1;
        aresetn = 1'b0;
        check_outputs("after_reset");
        cyc("post_reset_push", 1'b1, tag_phv(32'h5EED), 1'b0);
        check_val("post_reset_head", bus.phv_out, tag_phv(32'h5EED));
        drain("drain4");

        // Drop counter saturation from a preloaded value
        for (int t = 1; t <= 8; t++) cyc("fill3", 1'b1, tag_phv(t), 1'b0);
        force dut.drop_cnt_reg = 32'hFFFF_FFFD;
        #1;
        release dut.drop_cnt_reg;
        model_drops = 32'hFFFF_FFFD;
        for (int t = 0; t < 4; t++) cyc("saturate", 1'b1, tag_phv(t), 1'b0);
        check_val("drop_cnt_sat", PHV_LEN'(drop_cnt), PHV_LEN'(32'hFFFF_FFFF));
        drain("drain5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
